mem_byte_writer: RTL and testbench
==================================

Name: mem_byte_writer

Overview:
- Writer end of the byte-addressed, little-endian instruction/data memory array. The array is 8-bit wide, 2**ADDRESS_WIDTH deep, and its readers assemble each word as {mem[A+3], mem[A+2], mem[A+1], mem[A]}.
- Accepts 32-bit words over a valid/ready stream and serialises each one into four byte writes, least-significant byte at the lowest address.
- Used to load program images and test data into the array at run time, replacing file preload.

Parameters:
- ADDRESS_WIDTH, 16, byte-address width of the memory array.
- DATA_WIDTH, 32, word width; fixed at 32 (4 bytes per word).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; begins a load session at base_addr.
- base_addr  in  ADDRESS_WIDTH  byte address of the first byte; sampled on start.
- word_valid  in  1  upstream word available.
- word_data  in  32  word to write.
- word_last  in  1  qualifies word_data as the final word of the session.
- word_ready  out  1  writer can accept a word this cycle.
- mem_we  out  1  byte write enable to the array.
- mem_addr  out  ADDRESS_WIDTH  byte address for the write.
- mem_wdata  out  8  byte to write.
- busy  out  1  session in progress (any state other than IDLE).
- done  out  1  one-cycle pulse when the last byte of the session has been written.
- word_count  out  ADDRESS_WIDTH  number of words fully written in the current or last session.
- checksum  out  8  running byte sum; see Optional Feature.

Behaviour:
- Clock and reset are fixed: one clock, clk; synchronous active-high reset, rst.
- Reset values: state IDLE; word_ready 0; mem_we 0; mem_addr 0; mem_wdata 0; busy 0; done 0; word_count 0; checksum 0.
- FSM states: IDLE, ACCEPT, WRITE, DONE. A 2-bit byte index idx is used in WRITE.
- IDLE:
  - start=1: latch base_addr into pointer ptr, clear word_count (and checksum), go to ACCEPT.
  - start=0: stay in IDLE.
- ACCEPT:
  - word_ready=1.
  - On word_valid & word_ready: latch word_data and word_last, set idx=0, go to WRITE.
  - Otherwise wait with no timeout.
- WRITE:
  - mem_we=1, mem_addr=ptr, mem_wdata=word[8*idx+7 : 8*idx].
  - Each cycle: ptr increments by 1 and idx increments by 1.
  - At idx=3: word_count increments. If the latched last=1, go to DONE; otherwise go to ACCEPT.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- Outputs in each state:
  - word_ready is 1 only in ACCEPT.
  - mem_we is 1 only in WRITE.
  - mem_addr and mem_wdata are don't-care when mem_we=0 but must not be X after reset.
  - busy=1 in ACCEPT, WRITE and DONE.
- Throughput and latency:
  - Each word takes 1 ACCEPT cycle plus 4 WRITE cycles, i.e. 5 cycles per word.
  - The first mem_we occurs the cycle after the handshake.
  - done appears the cycle after the final byte write.
- Boundary conditions:
  - Address wrap: ptr is ADDRESS_WIDTH bits and wraps modulo 2**ADDRESS_WIDTH. For example, base 0xFFFE writes FFFE, FFFF, 0000, 0001.
  - word_count wraps modulo 2**ADDRESS_WIDTH.
  - start while busy is ignored; base_addr is not resampled.
  - word_valid outside ACCEPT is not acknowledged. word_data must be held by the source until the handshake.
  - rst during WRITE: the next edge returns to IDLE with mem_we=0. The partially written word is left as-is and no done is produced.
  - rst and start in the same cycle: rst wins.
  - word_last=1 on the first word gives a one-word session.

Optional Feature:
- Macro: MEM_BYTE_WRITER_CHECKSUM_EN.
- Defined:
  - checksum is an 8-bit register, cleared on start.
  - Each WRITE cycle adds mem_wdata modulo 256.
  - The value is held from DONE until the next start.
- Undefined:
  - checksum is tied to 0 and no adder or register is synthesised.

Test Plan:
- Reset, then idle 5 cycles -> all outputs 0; word_ready 0; busy 0.
- start with base_addr=0x0100; one word 0x12345678 with word_last=1 -> writes 78@0100, 56@0101, 34@0102, 12@0103 on consecutive cycles; done pulses once; word_count=1; checksum=0x14 with the macro defined, 0 without.
- start with base 0x0000; three words 0xDEADBEEF, 0x00000013, 0xCAFEF00D (last on the third), word_valid held high -> 12 byte writes at 0x0000..0x000B in little-endian order; word_ready high exactly 3 cycles; done 15 cycles after the first handshake; word_count=3.
- start with base 0xFFFE; word 0xAABBCCDD with last -> DD@FFFE, CC@FFFF, BB@0000, AA@0001.
- word_valid deasserted for 4 cycles between words -> writer stays in ACCEPT with mem_we=0; a second start pulse during this gap is ignored; session completes at the original addresses.
- rst asserted on the 2nd WRITE cycle of a word -> next cycle mem_we=0, busy=0, word_count=0; no done; a subsequent session completes normally.

Source files
------------

// File: rtl/mem_byte_writer_if.sv
// Word stream and byte-memory write bundle for mem_byte_writer.
// slave: writer side (takes words, drives byte writes); master: source/array side.
interface mem_byte_writer_if #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 32
);
    logic                     word_valid;
    logic [DATA_WIDTH-1:0]    word_data;
    logic                     word_last;
    logic                     word_ready;
    logic                     mem_we;
    logic [ADDRESS_WIDTH-1:0] mem_addr;
    logic [7:0]               mem_wdata;

    modport master (
        output word_valid, word_data, word_last,
        input  word_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  word_valid, word_data, word_last,
        output word_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_byte_writer.sv
// Serialises 32-bit words into little-endian byte writes to the memory array.
// Ports: clk, rst (sync, active-high), start/base_addr session control,
//   bus (word stream in, byte writes out), busy, done, word_count, checksum.
// Optional macro MEM_BYTE_WRITER_CHECKSUM_EN enables the running byte sum;
//   without it checksum is tied to zero.
module mem_byte_writer #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] base_addr,
    mem_byte_writer_if.slave         bus,
    output logic                     busy,
    output logic                     done,
    output logic [ADDRESS_WIDTH-1:0] word_count,
    output logic [7:0]               checksum
);

    typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, DONE} state_t;

    state_t                   state, state_n;
    logic [ADDRESS_WIDTH-1:0] ptr, ptr_n;
    logic [ADDRESS_WIDTH-1:0] cnt_n;
    logic [1:0]               idx, idx_n;
    logic [DATA_WIDTH-1:0]    word, word_n;
    logic                     last, last_n;
    logic [7:0]               byte_sel;

    // Byte idx of the latched word, LSB first.
    assign byte_sel = word[{idx, 3'b000} +: 8];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            idx        <= '0;
            word       <= '0;
            last       <= 1'b0;
            word_count <= '0;
        end else begin
            state      <= state_n;
            ptr        <= ptr_n;
            idx        <= idx_n;
            word       <= word_n;
            last       <= last_n;
            word_count <= cnt_n;
        end
    end

    always_comb begin
        state_n        = state;
        ptr_n          = ptr;
        idx_n          = idx;
        word_n         = word;
        last_n         = last;
        cnt_n          = word_count;
        bus.word_ready = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        busy           = (state != IDLE);
        done           = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    ptr_n   = base_addr;
                    cnt_n   = '0;
                    state_n = ACCEPT;
                end
            end
            ACCEPT: begin
                bus.word_ready = 1'b1;
                if (bus.word_valid) begin
                    word_n  = bus.word_data;
                    last_n  = bus.word_last;
                    idx_n   = 2'd0;
                    state_n = WRITE;
                end
            end
            WRITE: begin
                bus.mem_we    = 1'b1;
                bus.mem_addr  = ptr;
                bus.mem_wdata = byte_sel;
                ptr_n         = ptr + ADDRESS_WIDTH'(1);
                idx_n         = idx + 2'd1;
                if (idx == 2'd3) begin
                    cnt_n   = word_count + ADDRESS_WIDTH'(1);
                    state_n = last ? DONE : ACCEPT;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

`ifdef MEM_BYTE_WRITER_CHECKSUM_EN
    logic [7:0] sum_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= '0;
        end else if (state == IDLE && start) begin
            sum_q <= '0;
        end else if (state == WRITE) begin
            sum_q <= sum_q + byte_sel;
        end
    end

    assign checksum = sum_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_mem_byte_writer.sv
// Self-checking bench for mem_byte_writer: directed and random load sessions
// compared against a byte-level model of the expected memory writes.
module tb_mem_byte_writer;

    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic          busy;
    logic          done;
    logic [AW-1:0] word_count;
    logic [7:0]    checksum;

    mem_byte_writer_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(32)) bus();

    mem_byte_writer #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .bus        (bus.slave),
        .busy       (busy),
        .done       (done),
        .word_count (word_count),
        .checksum   (checksum)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int done_n   = 0;
    int ready_n  = 0;
    int first_we = -1;
    int done_cyc = -1;

    logic [AW-1:0] exp_addr[$];
    logic [7:0]    exp_data[$];
    logic [31:0]   words[$];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; sample at the falling edge and score any byte write.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (bus.mem_we === 1'b1) begin
            if (first_we < 0) first_we = cyc;
            check("we_expected", 32'(exp_addr.size() != 0), 32'd1);
            if (exp_addr.size() != 0) begin
                check("wr_addr", 32'(bus.mem_addr), 32'(exp_addr.pop_front()));
                check("wr_data", 32'(bus.mem_wdata), 32'(exp_data.pop_front()));
            end
        end
        if (done === 1'b1) begin
            done_n++;
            done_cyc = cyc;
        end
        if (bus.word_ready === 1'b1) ready_n++;
    endtask

    task automatic wait_ready();
        int bound = 0;
        while (bus.word_ready !== 1'b1 && bound < 20) begin
            tick();
            bound++;
        end
        check("ready_timeout", 32'(bound < 20), 32'd1);
    endtask

    // Full session over the words queue; gap idles the source between words.
    task automatic session(input logic [AW-1:0] b, input int gap,
                           input bit late_start);
        int          n = words.size();
        int          hs = -1;
        int          bound;
        logic [7:0]  sum = 8'd0;
        logic [7:0]  exp_cs;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < 4; j++) begin
                exp_addr.push_back(b + AW'(4 * i + j));
                exp_data.push_back(words[i][8 * j +: 8]);
                sum = sum + words[i][8 * j +: 8];
            end
        end
`ifdef MEM_BYTE_WRITER_CHECKSUM_EN
        exp_cs = sum;
`else
        exp_cs = 8'd0;
`endif
        done_n = 0;
        ready_n = 0;
        first_we = -1;
        done_cyc = -1;
        start = 1'b1;
        base_addr = b;
        tick();
        start = 1'b0;
        base_addr = AW'($urandom);
        check("busy_start", 32'(busy), 32'd1);
        for (int i = 0; i < n; i++) begin
            if (i > 0 && gap > 0) begin
                bus.word_valid = 1'b0;
                wait_ready();
                for (int g = 0; g < gap; g++) begin
                    check("gap_ready", 32'(bus.word_ready), 32'd1);
                    check("gap_we", 32'(bus.mem_we), 32'd0);
                    if (late_start && g == 0) begin
                        start = 1'b1;
                        base_addr = AW'($urandom);
                    end
                    tick();
                    start = 1'b0;
                end
            end
            bus.word_valid = 1'b1;
            bus.word_data = words[i];
            bus.word_last = (i == n - 1);
            wait_ready();
            if (i == 0) hs = cyc;
            tick();
            if (i == n - 1 || gap > 0) bus.word_valid = 1'b0;
        end
        bus.word_valid = 1'b0;
        bound = 0;
        while (done_cyc < 0 && bound < 30) begin
            tick();
            bound++;
        end
        check("done_seen", 32'(done_cyc >= 0), 32'd1);
        repeat (3) tick();
        check("done_once", 32'(done_n), 32'd1);
        check("writes_left", 32'(exp_addr.size()), 32'd0);
        check("word_count", 32'(word_count), 32'(n));
        check("checksum", 32'(checksum), 32'(exp_cs));
        check("busy_end", 32'(busy), 32'd0);
        check("ready_cycles", 32'(ready_n), 32'(n + gap * (n - 1)));
        check("first_we_lat", 32'(first_we - hs), 32'd1);
        check("done_lat", 32'(done_cyc - hs), 32'(5 * n + gap * (n - 1)));
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        base_addr = '0;
        bus.word_valid = 1'b0;
        bus.word_data = '0;
        bus.word_last = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("rst_we", 32'(bus.mem_we), 32'd0);
            check("rst_ready", 32'(bus.word_ready), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_done", 32'(done), 32'd0);
        end
        check("rst_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_wdata", 32'(bus.mem_wdata), 32'd0);
        check("rst_count", 32'(word_count), 32'd0);
        check("rst_cs", 32'(checksum), 32'd0);

        words = '{32'h12345678};
        session(16'h0100, 0, 1'b0);

        words = '{32'hDEADBEEF, 32'h00000013, 32'hCAFEF00D};
        session(16'h0000, 0, 1'b0);

        words = '{32'hAABBCCDD};
        session(16'hFFFE, 0, 1'b0);

        words = '{$urandom, $urandom, $urandom};
        session(AW'($urandom), 4, 1'b1);

        // Reset in the middle of a word: only its first two bytes land.
        words = '{$urandom};
        exp_addr.push_back(16'h2000);
        exp_addr.push_back(16'h2001);
        exp_data.push_back(words[0][7:0]);
        exp_data.push_back(words[0][15:8]);
        done_n = 0;
        start = 1'b1;
        base_addr = 16'h2000;
        tick();
        start = 1'b0;
        bus.word_valid = 1'b1;
        bus.word_data = words[0];
        bus.word_last = 1'b0;
        tick();
        bus.word_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_we", 32'(bus.mem_we), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_count", 32'(word_count), 32'd0);
        check("mid_rst_cs", 32'(checksum), 32'd0);
        repeat (3) tick();
        check("mid_rst_nodone", 32'(done_n), 32'd0);
        check("mid_rst_writes", 32'(exp_addr.size()), 32'd0);

        words = '{$urandom, $urandom};
        session(AW'($urandom), 0, 1'b0);

        for (int s = 0; s < 8; s++) begin
            int n = $urandom_range(1, 4);
            logic [AW-1:0] b;
            words.delete();
            for (int i = 0; i < n; i++) words.push_back($urandom);
            b = (s % 2 == 0) ? AW'(16'hFFF0 + $urandom_range(0, 15))
                             : AW'($urandom);
            session(b, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
